// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the weight-stationary systolic array sequencer.
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        SWITCH,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int DATA_WIDTH = 16;

    // The phase counter must hold the longest phase: ROWS, num_vecs or ROWS + COLS.
    function automatic int cnt_width(input int vec_w, input int rows, input int cols);
        int need;
        need = $clog2(rows + cols + 1);
        if ($clog2(rows + 1) > need) need = $clog2(rows + 1);
        if (vec_w > need) need = vec_w;
        return need;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Control, buffer-read and array-edge signals of the sequencer.
// master is the TPU control / buffer / array side, slave is the sequencer itself.
interface systolic_ctrl_if
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int ADDR_W = 8,
    parameter int VEC_W  = 8
);
    logic              start;
    logic [VEC_W-1:0]  num_vecs;
    logic [ADDR_W-1:0] wgt_base;
    logic [ADDR_W-1:0] in_base;
    logic              busy;
    logic              done;
    logic              wgt_rd_en;
    logic [ADDR_W-1:0] wgt_rd_addr;
    logic              in_rd_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [COLS-1:0]   arr_accept_w;
    logic [ROWS-1:0]   arr_switch;
    logic [ROWS-1:0]   arr_valid;
    logic              arr_enabled;
    logic [COLS-1:0]   out_valid;

    modport master (
        output start, num_vecs, wgt_base, in_base,
        input  busy, done, wgt_rd_en, wgt_rd_addr, in_rd_en, in_rd_addr,
        input  arr_accept_w, arr_switch, arr_valid, arr_enabled, out_valid
    );

    modport slave (
        input  start, num_vecs, wgt_base, in_base,
        output busy, done, wgt_rd_en, wgt_rd_addr, in_rd_en, in_rd_addr,
        output arr_accept_w, arr_switch, arr_valid, arr_enabled, out_valid
    );

endinterface

// File: rtl/systolic_ctrl_skew_delay.sv
// Per-lane shift register: lane i delays din[i] by BASE_DEPTH + i cycles.
module skew_delay #(
    parameter int LANES      = 2,
    parameter int BASE_DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] din,
    output logic [LANES-1:0] dout
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int D = BASE_DEPTH + i;
        logic [D-1:0] sr;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) sr <= '0;
            else     sr <= (sr << 1) | D'(din[i]);
        end

        assign dout[i] = sr[D-1];
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer: weight-tile load, switch commit, skewed input streaming and drain
// for a ROWS x COLS weight-stationary systolic array.
//
// state  | meaning
// IDLE   | waiting for start; array disabled
// LOAD_W | ROWS weight-row reads, bottom row first
// SWITCH | one cycle that launches the row-skewed switch pulse
// STREAM | num_vecs input-vector reads
// DRAIN  | ROWS + COLS cycles for the last psums to leave the array
// DONE   | one-cycle done pulse
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int ADDR_W = 8,
    parameter int VEC_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    systolic_ctrl_if.slave io
);

    localparam int CNT_W = cnt_width(VEC_W, ROWS, COLS);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROWS + COLS - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [VEC_W-1:0]  n_q;
    logic [ADDR_W-1:0] in_base_q;
    logic              wgt_rd_en_q;
    logic [ADDR_W-1:0] wgt_rd_addr_q;
    logic              in_rd_en_q;
    logic [ADDR_W-1:0] in_rd_addr_q;
    logic              sw_pulse;
    logic              busy_q;
    logic              done_q;
    logic [COLS-1:0]   accept_w_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            n_q           <= '0;
            in_base_q     <= '0;
            wgt_rd_en_q   <= 1'b0;
            wgt_rd_addr_q <= '0;
            in_rd_en_q    <= 1'b0;
            in_rd_addr_q  <= '0;
            sw_pulse      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.start) begin
                        state         <= LOAD_W;
                        cnt           <= LOAD_LAST;
                        n_q           <= io.num_vecs;
                        in_base_q     <= io.in_base;
                        wgt_rd_en_q   <= 1'b1;
                        wgt_rd_addr_q <= io.wgt_base;
                        busy_q        <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (cnt == '0) begin
                        state       <= SWITCH;
                        wgt_rd_en_q <= 1'b0;
                        sw_pulse    <= 1'b1;
                    end else begin
                        cnt           <= cnt - 1'b1;
                        wgt_rd_addr_q <= wgt_rd_addr_q + 1'b1;
                    end
                end
                SWITCH: begin
                    sw_pulse <= 1'b0;
                    if (n_q == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state        <= STREAM;
                        cnt          <= CNT_W'(n_q) - CNT_W'(1);
                        in_rd_en_q   <= 1'b1;
                        in_rd_addr_q <= in_base_q;
                    end
                end
                STREAM: begin
                    if (cnt == '0) begin
                        state      <= DRAIN;
                        cnt        <= DRAIN_LAST;
                        in_rd_en_q <= 1'b0;
                    end else begin
                        cnt          <= cnt - 1'b1;
                        in_rd_addr_q <= in_rd_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Weight data returns one cycle after the read strobe; accept it then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) accept_w_q <= '0;
        else     accept_w_q <= {COLS{wgt_rd_en_q}};
    end

    skew_delay #(.LANES(ROWS), .BASE_DEPTH(1)) u_switch_skew (
        .clk  (clk),
        .rst  (rst),
        .din  ({ROWS{sw_pulse}}),
        .dout (io.arr_switch)
    );

    skew_delay #(.LANES(ROWS), .BASE_DEPTH(1)) u_valid_skew (
        .clk  (clk),
        .rst  (rst),
        .din  ({ROWS{in_rd_en_q}}),
        .dout (io.arr_valid)
    );

    // Column c sees its psum ROWS + c + 1 cycles after the vector was read.
    skew_delay #(.LANES(COLS), .BASE_DEPTH(ROWS + 1)) u_out_skew (
        .clk  (clk),
        .rst  (rst),
        .din  ({COLS{in_rd_en_q}}),
        .dout (io.out_valid)
    );

    assign io.busy         = busy_q;
    assign io.done         = done_q;
    assign io.wgt_rd_en    = wgt_rd_en_q;
    assign io.wgt_rd_addr  = wgt_rd_addr_q;
    assign io.in_rd_en     = in_rd_en_q;
    assign io.in_rd_addr   = in_rd_addr_q;
    assign io.arr_accept_w = accept_w_q;
    assign io.arr_enabled  = busy_q;

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the ROWS x COLS weight-stationary systolic array of PEs. It loads one weight tile through the array's double-buffered weight path, commits it with a switch pulse, and streams a batch of input vectors with per-row skew. It then generates column-skewed output-valid strobes and drains the pipeline. It sits between the unified buffer's read ports and the array edge, and is started by the top-level TPU control.

## Interface
- ROWS, 2, array rows; also weight-tile depth
- COLS, 2, array columns
- ADDR_W, 8, buffer address width
- VEC_W, 8, width of the vector-count field
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- num_vecs  in  VEC_W  input vectors in the batch, latched on start
- wgt_base  in  ADDR_W  first weight-row address, latched on start
- in_base  in  ADDR_W  first input-vector address, latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on batch completion
- wgt_rd_en  out  1  weight buffer read strobe; data is returned 1 cycle later
- wgt_rd_addr  out  ADDR_W  weight row address
- in_rd_en  out  1  input buffer read strobe; data is returned 1 cycle later
- in_rd_addr  out  ADDR_W  input vector address
- arr_accept_w  out  COLS  accept_w into the top PE of each column
- arr_switch  out  ROWS  switch into the left PE of each row
- arr_valid  out  ROWS  valid into the left PE of each row (skewed)
- arr_enabled  out  1  PE enable; low only in IDLE
- out_valid  out  COLS  psum at the bottom of column c is valid

## Operation
- FSM states: IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE.
- IDLE: when start=1, latch num_vecs, wgt_base and in_base, then go to LOAD_W. Any start pulse outside IDLE is ignored.
- LOAD_W: runs for ROWS cycles.
  - Each cycle issues wgt_rd_en with wgt_rd_addr = wgt_base + k, k = 0..ROWS-1.
  - The weight for the last row is read first, so the caller stores the tile bottom-row-first.
  - arr_accept_w = all ones, delayed 1 cycle from wgt_rd_en so that it aligns with the returned data.
  - The state then advances to SWITCH.
- SWITCH: runs for 1 cycle.
  - arr_switch[0] is pulsed, aligned with the cycle after the last accept_w.
  - arr_switch[r] is the same pulse delayed r cycles.
  - If num_vecs = 0 the next state is DONE; otherwise STREAM.
- STREAM: runs for num_vecs cycles.
  - Each cycle issues in_rd_en with in_rd_addr = in_base + v.
  - arr_valid[r] = in_rd_en delayed 1 + r cycles, which provides the row skew.
- DRAIN: runs for ROWS + COLS cycles with no reads, then goes to DONE.
- DONE: done = 1 for 1 cycle, then IDLE.
- out_valid[c] = in_rd_en delayed ROWS + c + 1 cycles.
  - The delay line runs independently of the FSM state.
  - The DRAIN length guarantees that the last out_valid pulse occurs before done.
- Address arithmetic is modulo 2^ADDR_W; it wraps silently.
- Counters are sized to hold max(ROWS, num_vecs, ROWS + COLS).

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Reset is asynchronous, so assertion mid-batch clears all state and delay lines immediately with no done pulse.
- All outputs are registered or derived from registered state. There are no combinational paths from inputs to outputs.
- Latency from start (cycle 0) is fixed:
  - LOAD_W occupies cycles 1..ROWS.
  - SWITCH is cycle ROWS+1.
  - STREAM occupies cycles ROWS+2 .. ROWS+1+N.
  - DONE is cycle 2·ROWS + COLS + N + 2.
- With num_vecs = 0, done occurs at cycle ROWS+2.
- busy falls in the cycle after done. A start pulse in that same cycle is accepted (back-to-back batches).

## Structure
- A shared package holds:
  - the state enum: IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE;
  - the DATA_WIDTH = 16 constant shared with the PE.
- One sub-module, skew_delay, is a parameterised per-bit shift register with a depth per lane. It is instantiated for arr_switch, arr_valid and out_valid.

## Test plan
- ROWS=COLS=2: start with N=3, wgt_base=0x10, in_base=0x40.
  - Required: wgt reads at 0x10 and 0x11.
  - Required: accept_w = 2'b11 for 2 cycles, then a switch pulse.
  - Required: in reads at 0x40..0x42, then out_valid[0] ×3 followed by out_valid[1] ×3.
  - Required: done at cycle 11.
- N=0: no input reads and no out_valid; done at cycle 4.
- start re-asserted during STREAM: ignored, and the batch count is unchanged.
- Reset asserted mid-STREAM: all outputs are 0 immediately; the next start runs a clean batch.
- in_base=0xFE, N=4: addresses run 0xFE, 0xFF, 0x00, 0x01.
- Back-to-back: start in the cycle after done is accepted, and the second batch's timing is identical to the first.
